// File: rtl/cpu7_ifu_fetch_queue.sv
// cpu7_ifu_fetch_queue
//   Instruction fetch front end: fetch-PC generator, tracker for fetches that
//   have been issued but not yet returned, and a circular instruction queue
//   feeding the decoder. Several fetches can be in flight while decode stalls.
//
// Optional feature macro: CPU7_IFU_FQ_BYPASS_EN
//   Defined   - a kept response that arrives while the queue is empty is shown
//               to decode in the same cycle; it is only written into the queue
//               when decode is stalling.
//   Undefined - every response passes through the queue (one cycle latency).
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   pc_init               fetch PC loaded while reset is high
//   inst_req/inst_addr    fetch request and its address (registered fetch PC)
//   inst_addr_ok          request accepted by the memory side this cycle
//   inst_valid_f          in-order fetch response with rdata / ex / exccode
//   inst_cancel           one-cycle pulse in every redirect cycle
//   br_*, exu_ifu_*       branch / exception / ertn redirects, decode stall
//   fdp_dec_*             head-of-queue instruction presented to decode
module cpu7_ifu_fetch_queue #(
  parameter int DEPTH     = 4,
  parameter int MAX_OUTST = 2,
  parameter int AW        = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] pc_init,
  output logic          inst_req,
  output logic [AW-1:0] inst_addr,
  input  logic          inst_addr_ok,
  input  logic          inst_valid_f,
  input  logic [31:0]   inst_rdata_f,
  input  logic          inst_ex,
  input  logic [5:0]    inst_exccode,
  output logic          inst_cancel,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  input  logic          exu_ifu_except,
  input  logic [AW-1:0] exu_ifu_eentry,
  input  logic          exu_ifu_ertn_e,
  input  logic [AW-1:0] exu_ifu_era,
  input  logic          exu_ifu_stall_req,
  output logic          fdp_dec_valid,
  output logic [31:0]   fdp_dec_inst,
  output logic [AW-1:0] fdp_dec_pc,
  output logic          fdp_dec_ex,
  output logic [5:0]    fdp_dec_exccode
);

  localparam int QW = $clog2(DEPTH);
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam logic [OW-1:0] MaxOutst = OW'(MAX_OUTST);
  localparam logic [QW+1:0] DepthW   = (QW + 2)'(DEPTH);
  localparam logic [PW-1:0] PendLast = PW'(MAX_OUTST - 1);

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [31:0]   inst;
    logic          ex;
    logic [5:0]    code;
  } entry_t;

  logic [AW-1:0] fetchPc_q, fetchPc_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] discard_q, discard_d;
  logic [QW:0]   count_q, count_d;
  logic [QW-1:0] rdPtr_q, rdPtr_d;
  logic [QW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] pendRd_q, pendRd_d;
  logic [PW-1:0] pendWr_q, pendWr_d;
  logic [AW-1:0] pend_q [MAX_OUTST];
  entry_t        queue_q [DEPTH];

  logic          redirect;
  logic [AW-1:0] redirectTarget;
  logic [QW+1:0] occupancy;
  logic          accept;
  logic          respFire;
  logic          respKeep;
  logic          bypassHit;
  logic          decValid;
  logic          push;
  logic          pop;
  entry_t        respEntry;
  entry_t        headEntry;

  assign redirect = exu_ifu_except | exu_ifu_ertn_e | br_taken;

  // Exception outranks ertn, which outranks a branch.
  always_comb begin
    redirectTarget = br_target;
    if (exu_ifu_except) begin
      redirectTarget = exu_ifu_eentry;
    end else if (exu_ifu_ertn_e) begin
      redirectTarget = exu_ifu_era;
    end
  end

  // Outstanding fetches already own a queue slot, so a response can never
  // arrive to a full queue.
  assign occupancy   = {1'b0, count_q} + (QW + 2)'(outst_q);
  assign inst_req    = ~reset & ~redirect & (outst_q < MaxOutst) & (occupancy < DepthW);
  assign inst_addr   = fetchPc_q;
  assign inst_cancel = ~reset & redirect;
  assign accept      = inst_req & inst_addr_ok;

  // A response with nothing outstanding is ignored rather than underflowing.
  assign respFire  = ~reset & inst_valid_f & (outst_q != '0);
  assign respKeep  = respFire & ~redirect & (discard_q == '0);
  assign respEntry = '{pc: pend_q[pendRd_q], inst: inst_rdata_f, ex: inst_ex, code: inst_exccode};

`ifdef CPU7_IFU_FQ_BYPASS_EN
  assign bypassHit = respKeep & (count_q == '0);
`else
  assign bypassHit = 1'b0;
`endif

  assign decValid  = ~reset & ~redirect & ((count_q != '0) | bypassHit);
  assign headEntry = bypassHit ? respEntry : queue_q[rdPtr_q];
  assign pop       = decValid & ~exu_ifu_stall_req & ~bypassHit;
  assign push      = respKeep & ~(bypassHit & ~exu_ifu_stall_req);

  // Data outputs are forced to zero whenever nothing valid is presented.
  assign fdp_dec_valid   = decValid;
  assign fdp_dec_inst    = decValid ? headEntry.inst : '0;
  assign fdp_dec_pc      = decValid ? headEntry.pc   : '0;
  assign fdp_dec_ex      = decValid ? headEntry.ex   : 1'b0;
  assign fdp_dec_exccode = decValid ? headEntry.code : '0;

  // Next-state for PC, counters and pointers. A redirect flushes the queue and
  // marks every fetch still in flight after this cycle's response as stale.
  always_comb begin
    fetchPc_d = fetchPc_q;
    if (redirect) begin
      fetchPc_d = redirectTarget;
    end else if (accept) begin
      fetchPc_d = fetchPc_q + AW'(4);
    end

    outst_d  = outst_q + OW'(accept) - OW'(respFire);
    pendWr_d = pendWr_q;
    pendRd_d = pendRd_q;
    if (accept) begin
      pendWr_d = (pendWr_q == PendLast) ? '0 : pendWr_q + PW'(1);
    end
    if (respFire) begin
      pendRd_d = (pendRd_q == PendLast) ? '0 : pendRd_q + PW'(1);
    end

    discard_d = discard_q;
    count_d   = count_q;
    rdPtr_d   = rdPtr_q;
    wrPtr_d   = wrPtr_q;
    if (redirect) begin
      discard_d = outst_q - OW'(respFire);
      count_d   = '0;
      rdPtr_d   = '0;
      wrPtr_d   = '0;
    end else begin
      if (respFire && (discard_q != '0)) begin
        discard_d = discard_q - OW'(1);
      end
      count_d = count_q + (QW + 1)'(push) - (QW + 1)'(pop);
      rdPtr_d = rdPtr_q + QW'(pop);
      wrPtr_d = wrPtr_q + QW'(push);
    end
  end

  // Control state; reset discards queue contents and in-flight tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetchPc_q <= pc_init;
      outst_q   <= '0;
      discard_q <= '0;
      count_q   <= '0;
      rdPtr_q   <= '0;
      wrPtr_q   <= '0;
      pendRd_q  <= '0;
      pendWr_q  <= '0;
    end else begin
      fetchPc_q <= fetchPc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      count_q   <= count_d;
      rdPtr_q   <= rdPtr_d;
      wrPtr_q   <= wrPtr_d;
      pendRd_q  <= pendRd_d;
      pendWr_q  <= pendWr_d;
    end
  end

  // Storage arrays need no reset: the pointers and counts qualify every read.
  always_ff @(posedge clock) begin
    if (accept) begin
      pend_q[pendWr_q] <= inst_addr;
    end
    if (push) begin
      queue_q[wrPtr_q] <= respEntry;
    end
  end

endmodule

// File: tb/tb_cpu7_ifu_fetch_queue.sv
// tb_cpu7_ifu_fetch_queue
//   Bench for cpu7_ifu_fetch_queue. A queue-based model of the fetch front end
//   predicts the outputs every cycle; directed phases pin the model with
//   hand-computed addresses, then a long randomised phase follows.
`timescale 1ns/1ps
module tb_cpu7_ifu_fetch_queue;

  localparam int DEPTH     = 4;
  localparam int MAX_OUTST = 2;
  localparam int AW        = 32;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ex;
    logic [5:0]  code;
  } tbEntry;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc_init;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_valid_f;
  logic [31:0] inst_rdata_f;
  logic        inst_ex;
  logic [5:0]  inst_exccode;
  logic        inst_cancel;
  logic        br_taken;
  logic [31:0] br_target;
  logic        exu_ifu_except;
  logic [31:0] exu_ifu_eentry;
  logic        exu_ifu_ertn_e;
  logic [31:0] exu_ifu_era;
  logic        exu_ifu_stall_req;
  logic        fdp_dec_valid;
  logic [31:0] fdp_dec_inst;
  logic [31:0] fdp_dec_pc;
  logic        fdp_dec_ex;
  logic [5:0]  fdp_dec_exccode;

  cpu7_ifu_fetch_queue #(
    .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .AW(AW)
  ) dut (
    .clock(clock), .reset(reset), .pc_init(pc_init),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_valid_f(inst_valid_f), .inst_rdata_f(inst_rdata_f), .inst_ex(inst_ex),
    .inst_exccode(inst_exccode), .inst_cancel(inst_cancel),
    .br_taken(br_taken), .br_target(br_target),
    .exu_ifu_except(exu_ifu_except), .exu_ifu_eentry(exu_ifu_eentry),
    .exu_ifu_ertn_e(exu_ifu_ertn_e), .exu_ifu_era(exu_ifu_era),
    .exu_ifu_stall_req(exu_ifu_stall_req),
    .fdp_dec_valid(fdp_dec_valid), .fdp_dec_inst(fdp_dec_inst), .fdp_dec_pc(fdp_dec_pc),
    .fdp_dec_ex(fdp_dec_ex), .fdp_dec_exccode(fdp_dec_exccode)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  bit          rstK;
  int unsigned okPct, respPct, stallPct, exPct;
  bit          brK, exK, ertnK;
  logic [31:0] pcInitK, brTgtK, eentryK, eraK, exAddr;

  tbEntry      busQ[$];
  tbEntry      mQ[$];
  logic [31:0] mPend[$];
  int          mDiscard;
  logic [31:0] mFetchPc;
  tbEntry      decoded[$];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkDecodedEntry(input int idx, input logic [31:0] pc, input logic ex,
                                   input logic [5:0] code, input string name);
    if (idx < decoded.size()) begin
      checkOutput({name, "_pc"}, 64'(decoded[idx].pc), 64'(pc));
      checkOutput({name, "_ex"}, 64'(decoded[idx].ex), 64'(ex));
      checkOutput({name, "_code"}, 64'(decoded[idx].code), 64'(code));
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: got no decoded entry %0d expected pc %h", name, idx, pc);
    end
  endtask

  // Memory side: each accepted address gets random data; exAddr returns exccode 0x08.
  function automatic tbEntry makeBusEntry(input logic [31:0] a);
    tbEntry e;
    e.pc   = a;
    e.inst = $urandom;
    if (a == exAddr) begin
      e.ex   = 1'b1;
      e.code = 6'h08;
    end else if ($urandom_range(99) < exPct) begin
      e.ex   = 1'b1;
      e.code = 6'($urandom_range(63));
    end else begin
      e.ex   = 1'b0;
      e.code = 6'h00;
    end
    return e;
  endfunction

  task automatic applyStimulus();
    reset             = rstK;
    pc_init           = pcInitK;
    inst_addr_ok      = ($urandom_range(99) < okPct);
    exu_ifu_stall_req = ($urandom_range(99) < stallPct);
    br_taken          = brK;
    exu_ifu_except    = exK;
    exu_ifu_ertn_e    = ertnK;
    br_target         = brTgtK;
    exu_ifu_eentry    = eentryK;
    exu_ifu_era       = eraK;
    if (rstK) begin
      inst_valid_f = 1'b1;
      inst_rdata_f = $urandom;
      inst_ex      = 1'($urandom_range(1));
      inst_exccode = 6'($urandom_range(63));
    end else if (busQ.size() > 0 && $urandom_range(99) < respPct) begin
      inst_valid_f = 1'b1;
      inst_rdata_f = busQ[0].inst;
      inst_ex      = busQ[0].ex;
      inst_exccode = busQ[0].code;
    end else begin
      inst_valid_f = 1'b0;
      inst_rdata_f = $urandom;
      inst_ex      = 1'b0;
      inst_exccode = 6'h00;
    end
    brK   = 1'b0;
    exK   = 1'b0;
    ertnK = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    applyStimulus();
    @(negedge clock);
    #2;
    if (!reset && fdp_dec_valid && !exu_ifu_stall_req) begin
      decoded.push_back('{fdp_dec_pc, fdp_dec_inst, fdp_dec_ex, fdp_dec_exccode});
    end
  endtask

  // Reference model: pending fetch addresses and the instruction queue are
  // plain SV queues; expected outputs come from their sizes and heads.
  always @(negedge clock) begin : modelCompare
    bit          redirect, expReq, accept, respValid, keep, bypassHit, expValid;
    tbEntry      resp, head;
    redirect = exu_ifu_except | exu_ifu_ertn_e | br_taken;
    if (reset) begin
      checkOutput("rst_req", 64'(inst_req), 64'd0);
      checkOutput("rst_cancel", 64'(inst_cancel), 64'd0);
      checkOutput("rst_valid", 64'(fdp_dec_valid), 64'd0);
      checkOutput("rst_pc", 64'(fdp_dec_pc), 64'd0);
      checkOutput("rst_inst", 64'(fdp_dec_inst), 64'd0);
      checkOutput("rst_ex", 64'(fdp_dec_ex), 64'd0);
      checkOutput("rst_code", 64'(fdp_dec_exccode), 64'd0);
      mFetchPc = pc_init;
      mPend.delete();
      mQ.delete();
      busQ.delete();
      mDiscard = 0;
    end else begin
      expReq    = !redirect && (mPend.size() < MAX_OUTST) && ((mQ.size() + mPend.size()) < DEPTH);
      accept    = expReq && inst_addr_ok;
      respValid = inst_valid_f && (mPend.size() > 0);
      keep      = respValid && !redirect && (mDiscard == 0);
      resp      = '{32'h0, 32'h0, 1'b0, 6'h0};
      head      = '{32'h0, 32'h0, 1'b0, 6'h0};
      if (respValid) begin
        resp = '{mPend[0], inst_rdata_f, inst_ex, inst_exccode};
      end
      bypassHit = 1'b0;
`ifdef CPU7_IFU_FQ_BYPASS_EN
      bypassHit = keep && (mQ.size() == 0);
`endif
      if (bypassHit) begin
        expValid = 1'b1;
        head     = resp;
      end else begin
        expValid = !redirect && (mQ.size() > 0);
        if (expValid) head = mQ[0];
      end

      checkOutput("req", 64'(inst_req), 64'(expReq));
      checkOutput("addr", 64'(inst_addr), 64'(mFetchPc));
      checkOutput("cancel", 64'(inst_cancel), 64'(redirect));
      checkOutput("dec_valid", 64'(fdp_dec_valid), 64'(expValid));
      if (expValid) begin
        checkOutput("dec_pc", 64'(fdp_dec_pc), 64'(head.pc));
        checkOutput("dec_inst", 64'(fdp_dec_inst), 64'(head.inst));
        checkOutput("dec_ex", 64'(fdp_dec_ex), 64'(head.ex));
        checkOutput("dec_code", 64'(fdp_dec_exccode), 64'(head.code));
      end

      if (expValid && !exu_ifu_stall_req && !bypassHit) void'(mQ.pop_front());
      if (respValid) begin
        void'(mPend.pop_front());
        void'(busQ.pop_front());
      end
      if (redirect) begin
        mDiscard = mPend.size();
        mQ.delete();
        if (exu_ifu_except)      mFetchPc = exu_ifu_eentry;
        else if (exu_ifu_ertn_e) mFetchPc = exu_ifu_era;
        else                     mFetchPc = br_target;
      end else if (respValid && mDiscard > 0) begin
        mDiscard--;
      end else if (keep && !(bypassHit && !exu_ifu_stall_req)) begin
        mQ.push_back(resp);
      end
      if (accept) begin
        mPend.push_back(mFetchPc);
        busQ.push_back(makeBusEntry(mFetchPc));
        mFetchPc = mFetchPc + 32'd4;
      end
    end
  end

  initial begin
    rstK     = 1'b1;
    okPct    = 100;
    respPct  = 100;
    stallPct = 0;
    exPct    = 0;
    brK      = 1'b0;
    exK      = 1'b0;
    ertnK    = 1'b0;
    pcInitK  = 32'h1c00_0000;
    brTgtK   = 32'h0;
    eentryK  = 32'h0;
    eraK     = 32'h0;
    exAddr   = 32'hffff_fff0;
    applyStimulus();
    repeat (3) step();

    // Straight-line fetch after reset
    rstK = 1'b0;
    decoded.delete();
    step();
    checkOutput("a_addr0", 64'(inst_addr), 64'h1c00_0000);
    checkOutput("a_req0", 64'(inst_req), 64'd1);
    step();
    checkOutput("a_addr1", 64'(inst_addr), 64'h1c00_0004);
    step();
    checkOutput("a_addr2", 64'(inst_addr), 64'h1c00_0008);
    repeat (4) step();
    checkDecodedEntry(0, 32'h1c00_0000, 1'b0, 6'h00, "a_dec0");
    checkDecodedEntry(1, 32'h1c00_0004, 1'b0, 6'h00, "a_dec1");

    // Stalled decode fills the queue, then drains in order
    stallPct = 100;
    brK      = 1'b1;
    brTgtK   = 32'h1c00_0200;
    step();
    repeat (10) step();
    checkOutput("b_req_full", 64'(inst_req), 64'd0);
    checkOutput("b_valid", 64'(fdp_dec_valid), 64'd1);
    checkOutput("b_head", 64'(fdp_dec_pc), 64'h1c00_0200);
    stallPct = 0;
    decoded.delete();
    repeat (8) step();
    checkDecodedEntry(0, 32'h1c00_0200, 1'b0, 6'h00, "b_dec0");
    checkDecodedEntry(1, 32'h1c00_0204, 1'b0, 6'h00, "b_dec1");
    checkDecodedEntry(2, 32'h1c00_0208, 1'b0, 6'h00, "b_dec2");
    checkDecodedEntry(3, 32'h1c00_020c, 1'b0, 6'h00, "b_dec3");

    // Branch with two fetches in flight
    respPct = 0;
    repeat (3) step();
    checkOutput("c_req_maxoutst", 64'(inst_req), 64'd0);
    decoded.delete();
    brK    = 1'b1;
    brTgtK = 32'h1c00_0100;
    step();
    checkOutput("c_cancel", 64'(inst_cancel), 64'd1);
    checkOutput("c_req", 64'(inst_req), 64'd0);
    checkOutput("c_valid", 64'(fdp_dec_valid), 64'd0);
    respPct = 100;
    step();
    checkOutput("c_addr", 64'(inst_addr), 64'h1c00_0100);
    repeat (8) step();
    checkDecodedEntry(0, 32'h1c00_0100, 1'b0, 6'h00, "c_dec0");

    // Exception beats branch; faulting fetch at 0x1c008008
    exK     = 1'b1;
    brK     = 1'b1;
    eentryK = 32'h1c00_8000;
    brTgtK  = 32'h1c00_0300;
    exAddr  = 32'h1c00_8008;
    step();
    decoded.delete();
    step();
    checkOutput("d_addr", 64'(inst_addr), 64'h1c00_8000);
    repeat (8) step();
    checkDecodedEntry(0, 32'h1c00_8000, 1'b0, 6'h00, "d_dec0");
    checkDecodedEntry(1, 32'h1c00_8004, 1'b0, 6'h00, "d_dec1");
    checkDecodedEntry(2, 32'h1c00_8008, 1'b1, 6'h08, "d_dec_ex");

    // Return from exception
    ertnK = 1'b1;
    eraK  = 32'h1c00_0010;
    step();
    decoded.delete();
    step();
    checkOutput("e_addr", 64'(inst_addr), 64'h1c00_0010);
    repeat (6) step();
    checkDecodedEntry(0, 32'h1c00_0010, 1'b0, 6'h00, "e_dec0");

    // Reset in the middle of a stalled burst, with responses arriving during it
    stallPct = 100;
    repeat (3) step();
    rstK    = 1'b1;
    pcInitK = 32'h1c00_0040;
    repeat (2) step();
    rstK     = 1'b0;
    stallPct = 0;
    decoded.delete();
    step();
    checkOutput("f_valid", 64'(fdp_dec_valid), 64'd0);
    checkOutput("f_addr", 64'(inst_addr), 64'h1c00_0040);
    checkOutput("f_req", 64'(inst_req), 64'd1);
    repeat (6) step();
    checkDecodedEntry(0, 32'h1c00_0040, 1'b0, 6'h00, "f_dec0");

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        okPct    = $urandom_range(100, 20);
        respPct  = $urandom_range(100, 20);
        stallPct = $urandom_range(70, 0);
        exPct    = 10;
      end
      if ($urandom_range(99) < 3) begin
        brK     = 1'($urandom_range(1));
        exK     = 1'($urandom_range(1));
        ertnK   = 1'($urandom_range(1));
        if (!(brK || exK || ertnK)) brK = 1'b1;
        brTgtK  = $urandom & 32'hffff_fffc;
        eentryK = $urandom & 32'hffff_fffc;
        eraK    = $urandom & 32'hffff_fffc;
      end
      rstK = ($urandom_range(999) == 0);
      step();
    end
    rstK = 1'b0;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
